// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared constants, state codes and width helpers for the SVM datapath
package svm_pkg;

    localparam int XLEN_PIXEL_DEF    = 8;
    localparam int NUM_OF_PIXELS_DEF = 10;
    localparam int NUM_OF_SV_DEF     = 10;
    localparam int WAIT_MAX_DEF      = 64;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_KRST   = 3'd1;
    localparam state_t ST_STREAM = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_WAIT   = 3'd4;
    localparam state_t ST_ACC    = 3'd5;
    localparam state_t ST_FIN    = 3'd6;

    // Index width for a range of n entries; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Decision-sum width: kernel value width plus headroom for nsv additions.
    function automatic int result_w(input int xlen, input int nsv);
        return 2 * xlen + $clog2(nsv + 1);
    endfunction

endpackage

// File: rtl/sv_addr_gen.sv
// rtl/sv_addr_gen.sv - pixel/support-vector counters and SV RAM address
module sv_addr_gen
    import svm_pkg::*;
#(
    parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
    parameter int NUM_OF_SV     = NUM_OF_SV_DEF,
    parameter int PIX_W         = idx_w(NUM_OF_PIXELS),
    parameter int SV_W          = idx_w(NUM_OF_SV),
    parameter int SVA_W         = idx_w(NUM_OF_SV * NUM_OF_PIXELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             pix_step,
    input  logic             sv_step,
    output logic [PIX_W-1:0] pix_idx,
    output logic [SV_W-1:0]  sv_idx,
    output logic [SVA_W-1:0] sv_addr,
    output logic             pix_last,
    output logic             sv_last
);

    localparam logic [SVA_W-1:0] PIX_STRIDE = SVA_W'(NUM_OF_PIXELS);

    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic [SV_W-1:0]  sv_idx_q, sv_idx_d;

    assign pix_last = (pix_idx_q == PIX_W'(NUM_OF_PIXELS - 1));
    assign sv_last  = (sv_idx_q == SV_W'(NUM_OF_SV - 1));

    // Pixel index wraps after the last pixel; SV index only advances between vectors.
    always_comb begin
        pix_idx_d = pix_idx_q;
        sv_idx_d  = sv_idx_q;
        if (clr) begin
            pix_idx_d = '0;
            sv_idx_d  = '0;
        end else begin
            if (pix_step) begin
                pix_idx_d = pix_last ? '0 : pix_idx_q + PIX_W'(1);
            end
            if (sv_step) begin
                sv_idx_d = sv_idx_q + SV_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_idx_q <= '0;
            sv_idx_q  <= '0;
        end else begin
            pix_idx_q <= pix_idx_d;
            sv_idx_q  <= sv_idx_d;
        end
    end

    assign pix_idx = pix_idx_q;
    assign sv_idx  = sv_idx_q;
    assign sv_addr = SVA_W'(sv_idx_q) * PIX_STRIDE + SVA_W'(pix_idx_q);

endmodule

// File: rtl/hwf_sv_streamer.sv
// rtl/hwf_sv_streamer.sv - walks all support vectors through hwf_kernel and sums the results
module hwf_sv_streamer
    import svm_pkg::*;
#(
    parameter int XLEN_PIXEL    = XLEN_PIXEL_DEF,
    parameter int NUM_OF_PIXELS = NUM_OF_PIXELS_DEF,
    parameter int NUM_OF_SV     = NUM_OF_SV_DEF,
    parameter int WAIT_MAX      = WAIT_MAX_DEF,
    localparam int TAW = idx_w(NUM_OF_PIXELS),
    localparam int SAW = idx_w(NUM_OF_SV * NUM_OF_PIXELS),
    localparam int BAW = idx_w(NUM_OF_SV),
    localparam int KW  = 2 * XLEN_PIXEL,
    localparam int RW  = result_w(XLEN_PIXEL, NUM_OF_SV)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [TAW-1:0]        test_addr,
    input  logic [XLEN_PIXEL-1:0] test_rdata,
    output logic [SAW-1:0]        sv_addr,
    input  logic [XLEN_PIXEL-1:0] sv_rdata,
    output logic [BAW-1:0]        bi_addr,
    input  logic [KW-1:0]         bi_rdata,
    output logic                  kernel_rst,
    output logic                  stall_MEM,
    output logic [XLEN_PIXEL-1:0] x_test,
    output logic [XLEN_PIXEL-1:0] x_sv,
    output logic [KW-1:0]         Bi,
    input  logic                  hwf_done,
    input  logic [KW-1:0]         hwf_out,
    output logic                  busy,
    output logic [RW-1:0]         result,
    output logic                  result_valid,
    output logic                  timeout_err
);

    localparam int CW = idx_w(WAIT_MAX);

    state_t         state_q, state_d;
    logic [CW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [KW-1:0]  kval_q, kval_d;
    logic [RW-1:0]  acc_q, acc_d;
    logic [KW-1:0]  bi_q, bi_d;
    logic           bi_load_q, bi_load_d;
    logic           stall_q, stall_d;
    logic           terr_q, terr_d;

    logic           clr, pix_step, sv_step, pix_last, sv_last;

    sv_addr_gen #(
        .NUM_OF_PIXELS(NUM_OF_PIXELS),
        .NUM_OF_SV    (NUM_OF_SV),
        .PIX_W        (TAW),
        .SV_W         (BAW),
        .SVA_W        (SAW)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .pix_step(pix_step),
        .sv_step (sv_step),
        .pix_idx (test_addr),
        .sv_idx  (bi_addr),
        .sv_addr (sv_addr),
        .pix_last(pix_last),
        .sv_last (sv_last)
    );

    // Sequencing FSM; hwf_done is only looked at in WAIT, so a level left over from the previous SV is harmless.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        kval_d     = kval_q;
        acc_d      = acc_q;
        terr_d     = terr_q;
        clr        = 1'b0;
        pix_step   = 1'b0;
        sv_step    = 1'b0;
        // Bi RAM answers the KRST-cycle address one cycle later.
        bi_load_d  = (state_q == ST_KRST);
        bi_d       = bi_load_q ? bi_rdata : bi_q;
        // RAM data trails the address by one cycle, so stall follows the address phase.
        stall_d    = (state_q != ST_STREAM);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_KRST;
                    clr     = 1'b1;
                    acc_d   = '0;
                    terr_d  = 1'b0;
                end
            end
            ST_KRST: state_d = ST_STREAM;
            ST_STREAM: begin
                pix_step = 1'b1;
                if (pix_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (hwf_done) begin
                    kval_d  = hwf_out;
                    state_d = ST_ACC;
                end else if (wait_cnt_q == CW'(WAIT_MAX - 1)) begin
                    kval_d  = '0;
                    terr_d  = 1'b1;
                    state_d = ST_ACC;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_ACC: begin
                acc_d = acc_q + RW'(kval_q);
                if (sv_last) begin
                    state_d = ST_FIN;
                end else begin
                    sv_step = 1'b1;
                    state_d = ST_KRST;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            kval_q     <= '0;
            acc_q      <= '0;
            bi_q       <= '0;
            bi_load_q  <= 1'b0;
            stall_q    <= 1'b1;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            kval_q     <= kval_d;
            acc_q      <= acc_d;
            bi_q       <= bi_d;
            bi_load_q  <= bi_load_d;
            stall_q    <= stall_d;
            terr_q     <= terr_d;
        end
    end

    assign kernel_rst   = (state_q == ST_KRST);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FIN);
    assign result_valid = (state_q == ST_FIN);
    assign result       = acc_q;
    assign timeout_err  = terr_q;
    assign stall_MEM    = stall_q;
    assign Bi           = bi_q;
    assign x_test       = test_rdata;
    assign x_sv         = sv_rdata;

endmodule
